// File: rtl/midi_pkg.sv
// midi_pkg
//   Shared definitions for the MIDI note receiver: byte-receiver and parser
//   state enums, the status byte constants the parser decodes, the default
//   bit period and a small majority-vote helper used by the bit sampler.
package midi_pkg;

  // Clocks per MIDI bit at 65 MHz (31.25 kbaud).
  localparam int DEFAULT_COUNT = 2080;

  // Status byte boundaries: 0x8n note-off, 0x9n note-on, 0xF8.. real-time.
  localparam logic [7:0] STATUS_NOTE_OFF = 8'h80;
  localparam logic [7:0] STATUS_NOTE_ON  = 8'h90;
  localparam logic [7:0] STATUS_REALTIME = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_KEY,
    P_VEL
  } parser_state_t;

  // 2-of-3 vote; used to reject a single noisy sample around mid-bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx
//   Serial byte receiver for a MIDI line (8N1, idle high).
//   Ports:
//     clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//     serial      - raw asynchronous MIDI line
//     rx_byte     - last correctly framed byte, valid with rx_strobe
//     rx_strobe   - one-cycle pulse, a new byte is available
//     frame_err   - one-cycle pulse, the stop bit was sampled low
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int COUNT = DEFAULT_COUNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int TW = $clog2(COUNT + 1);

  // Timer value k (outside START) means k+1 clocks after the previous
  // mid-bit sample, so the next mid-bit lands on COUNT-1 and the three
  // votes are taken at COUNT-2, COUNT-1 and COUNT.
  localparam logic [TW-1:0] HALF   = TW'(COUNT / 2);
  localparam logic [TW-1:0] EARLY  = TW'(COUNT - 2);
  localparam logic [TW-1:0] MID    = TW'(COUNT - 1);
  localparam logic [TW-1:0] LATE   = TW'(COUNT);
  localparam logic [TW-1:0] ONE    = TW'(1);

  logic [1:0]    sync_q;
  logic          serial_s;
  rx_state_t     state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          s_early;
  logic          s_mid;
  logic          bit_vote;

  assign serial_s = sync_q[1];
  assign bit_vote = majority3(s_early, s_mid, serial_s);

  // Two-flop synchronizer; resets to the idle (high) line level so a
  // reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial};
    end
  end

  // Byte framing FSM. A start edge is confirmed at half a bit; the timer is
  // then re-based on that mid-start point so every later sample is taken
  // near the centre of its bit. Strobe and error are registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      s_early   <= 1'b1;
      s_mid     <= 1'b1;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!serial_s) begin
            state <= START;
          end
        end
        START: begin
          if (timer == HALF) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= serial_s ? IDLE : DATA;
          end else begin
            timer <= timer + ONE;
          end
        end
        DATA: begin
          if (timer == EARLY) begin
            s_early <= serial_s;
          end
          if (timer == MID) begin
            s_mid <= serial_s;
          end
          if (timer == LATE) begin
            shift_q <= {bit_vote, shift_q[7:1]};
            timer   <= ONE;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            timer <= timer + ONE;
          end
        end
        STOP: begin
          if (timer == MID) begin
            if (serial_s) begin
              rx_byte   <= shift_q;
              rx_strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end else begin
            timer <= timer + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_rx.sv
// midi_rx
//   MIDI note-on / note-off receiver with running status and channel filter.
//   Ports:
//     clk, rst_n    - clock (rising edge) and asynchronous active-low reset
//     serial        - raw asynchronous MIDI line, idle high
//     msg_valid     - one-cycle pulse, a complete note message is present
//     msg_note_on   - 1 = note-on with non-zero velocity, 0 = note-off
//     msg_key       - key number
//     msg_velocity  - velocity
//     msg_channel   - channel nibble of the status byte
//     frame_err     - one-cycle pulse, a byte had a low stop bit
module midi_rx
  import midi_pkg::*;
#(
  parameter int         COUNT   = DEFAULT_COUNT,
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial,
  output logic       msg_valid,
  output logic       msg_note_on,
  output logic [6:0] msg_key,
  output logic [6:0] msg_velocity,
  output logic [3:0] msg_channel,
  output logic       frame_err
);

  logic [7:0]    rx_byte;
  logic          rx_strobe;
  parser_state_t p_state;
  logic          rs_is_on;
  logic [3:0]    rs_chan;
  logic [6:0]    key_q;
  logic          chan_ok;

  midi_uart_rx #(
    .COUNT(COUNT)
  ) u_uart (
    .clk      (clk),
    .rst_n    (rst_n),
    .serial   (serial),
    .rx_byte  (rx_byte),
    .rx_strobe(rx_strobe),
    .frame_err(frame_err)
  );

  assign chan_ok = OMNI || (rs_chan == CHANNEL);

  // Note-message parser. Real-time bytes are transparent, note status bytes
  // load running status, any other status byte drops it. Data bytes
  // alternate key/velocity while running status is held, so repeated
  // key/velocity pairs need no new status byte. A framing error in the
  // middle of a message drops only the key already taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state      <= P_IDLE;
      rs_is_on     <= 1'b0;
      rs_chan      <= '0;
      key_q        <= '0;
      msg_valid    <= 1'b0;
      msg_note_on  <= 1'b0;
      msg_key      <= '0;
      msg_velocity <= '0;
      msg_channel  <= '0;
    end else begin
      msg_valid <= 1'b0;
      if (rx_strobe) begin
        if (rx_byte >= STATUS_REALTIME) begin
          p_state <= p_state;
        end else if (rx_byte[7]) begin
          if (rx_byte[7:5] == STATUS_NOTE_OFF[7:5]) begin
            rs_is_on <= (rx_byte[7:4] == STATUS_NOTE_ON[7:4]);
            rs_chan  <= rx_byte[3:0];
            p_state  <= P_KEY;
          end else begin
            p_state <= P_IDLE;
          end
        end else begin
          case (p_state)
            P_KEY: begin
              key_q   <= rx_byte[6:0];
              p_state <= P_VEL;
            end
            P_VEL: begin
              p_state <= P_KEY;
              if (chan_ok) begin
                msg_valid    <= 1'b1;
                msg_note_on  <= rs_is_on && (rx_byte[6:0] != 7'd0);
                msg_key      <= key_q;
                msg_velocity <= rx_byte[6:0];
                msg_channel  <= rs_chan;
              end
            end
            default: p_state <= p_state;
          endcase
        end
      end else if (frame_err && (p_state == P_VEL)) begin
        p_state <= P_KEY;
      end
    end
  end

endmodule

// File: tb/tb_midi_rx.sv
// tb_midi_rx
//   Self-checking bench for midi_rx. Two instances share one serial line:
//   dut1 in omni mode, dut2 filtered to channel 2. A byte table drives the
//   line; each entry carries the message it should complete, which is
//   queued per instance and popped when that instance pulses msg_valid.
//   Hand-written sequences cover the start-bit glitch and reset mid-byte.
`timescale 1ns / 1ps
module tb_midi_rx;

  localparam int COUNT = 208;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       exp_msg;
    logic       exp_on;
    logic [6:0] exp_key;
    logic [6:0] exp_vel;
    logic [3:0] exp_chan;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial = 1'b1;

  logic       m1_valid, m1_on, f1_err;
  logic [6:0] m1_key, m1_vel;
  logic [3:0] m1_chan;
  logic       m2_valid, m2_on, f2_err;
  logic [6:0] m2_key, m2_vel;
  logic [3:0] m2_chan;

  logic [18:0] q1[$];
  logic [18:0] q2[$];
  logic [18:0] last1, last2;
  bit          have1 = 0, have2 = 0;
  int          exp_msg1 = 0, exp_msg2 = 0, seen_msg1 = 0, seen_msg2 = 0;
  int          exp_ferr = 0, seen_ferr1 = 0, seen_ferr2 = 0;
  int          check_cnt = 0, pass_cnt = 0;
  vec_t        vecs[$];

  midi_rx #(.COUNT(COUNT), .OMNI(1'b1), .CHANNEL(4'd0)) dut1 (
    .clk(clk), .rst_n(rst_n), .serial(serial),
    .msg_valid(m1_valid), .msg_note_on(m1_on), .msg_key(m1_key),
    .msg_velocity(m1_vel), .msg_channel(m1_chan), .frame_err(f1_err)
  );

  midi_rx #(.COUNT(COUNT), .OMNI(1'b0), .CHANNEL(4'd2)) dut2 (
    .clk(clk), .rst_n(rst_n), .serial(serial),
    .msg_valid(m2_valid), .msg_note_on(m2_on), .msg_key(m2_key),
    .msg_velocity(m2_vel), .msg_channel(m2_chan), .frame_err(f2_err)
  );

  always #5 clk = ~clk;

  // Single comparison point: every check steps both counters here.
  task automatic checkOutput(input bit ok, input string name,
                             input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (ok) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic addVec(input logic [7:0] d, input logic s, input logic m,
                        input logic on, input logic [6:0] k,
                        input logic [6:0] v, input logic [3:0] c);
    vec_t t;
    t.data = d; t.stop_ok = s; t.exp_msg = m; t.exp_on = on;
    t.exp_key = k; t.exp_vel = v; t.exp_chan = c;
    vecs.push_back(t);
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 8N1 byte; a bad frame holds the stop bit low past its centre, then
  // releases the line early enough for the receiver to reject it as a start.
  task automatic sendByte(input logic [7:0] d, input logic stop_ok);
    serial = 1'b0;
    waitClocks(COUNT);
    for (int i = 0; i < 8; i++) begin
      serial = d[i];
      waitClocks(COUNT);
    end
    if (stop_ok) begin
      serial = 1'b1;
      waitClocks(COUNT);
    end else begin
      serial = 1'b0;
      waitClocks(COUNT * 3 / 4);
      serial = 1'b1;
      waitClocks(COUNT / 4 + COUNT);
    end
  endtask

  task automatic checkCounts(input string tag);
    checkOutput(seen_msg1 == exp_msg1, {tag, " dut1 msg count"}, seen_msg1, exp_msg1);
    checkOutput(seen_msg2 == exp_msg2, {tag, " dut2 msg count"}, seen_msg2, exp_msg2);
    checkOutput(seen_ferr1 == exp_ferr, {tag, " dut1 frame_err count"}, seen_ferr1, exp_ferr);
    checkOutput(seen_ferr2 == exp_ferr, {tag, " dut2 frame_err count"}, seen_ferr2, exp_ferr);
    if (have1)
      checkOutput({m1_on, m1_key, m1_vel, m1_chan} == last1, {tag, " dut1 held fields"},
                  {m1_on, m1_key, m1_vel, m1_chan}, last1);
    if (have2)
      checkOutput({m2_on, m2_key, m2_vel, m2_chan} == last2, {tag, " dut2 held fields"},
                  {m2_on, m2_key, m2_vel, m2_chan}, last2);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [18:0] e;
    e = {v.exp_on, v.exp_key, v.exp_vel, v.exp_chan};
    if (v.exp_msg) begin
      q1.push_back(e); exp_msg1++; last1 = e; have1 = 1;
      if (v.exp_chan == 4'd2) begin
        q2.push_back(e); exp_msg2++; last2 = e; have2 = 1;
      end
    end
    if (!v.stop_ok) exp_ferr++;
    sendByte(v.data, v.stop_ok);
    checkCounts($sformatf("vec%0d", idx));
  endtask

  // Scoreboard monitors, sampled on the falling edge away from updates.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m1_valid) begin
        seen_msg1++;
        if (q1.size() == 0) checkOutput(0, "dut1 unexpected msg", {m1_on, m1_key, m1_vel, m1_chan}, 0);
        else begin
          logic [18:0] e1;
          e1 = q1.pop_front();
          checkOutput({m1_on, m1_key, m1_vel, m1_chan} == e1, "dut1 msg fields",
                      {m1_on, m1_key, m1_vel, m1_chan}, e1);
        end
        if (f1_err) checkOutput(0, "dut1 msg_valid with frame_err", 1, 0);
      end
      if (f1_err) seen_ferr1++;
      if (m2_valid) begin
        seen_msg2++;
        if (q2.size() == 0) checkOutput(0, "dut2 unexpected msg", {m2_on, m2_key, m2_vel, m2_chan}, 0);
        else begin
          logic [18:0] e2;
          e2 = q2.pop_front();
          checkOutput({m2_on, m2_key, m2_vel, m2_chan} == e2, "dut2 msg fields",
                      {m2_on, m2_key, m2_vel, m2_chan}, e2);
        end
        if (f2_err) checkOutput(0, "dut2 msg_valid with frame_err", 1, 0);
      end
      if (f2_err) seen_ferr2++;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Basic note-on, then running-status note-on with velocity 0.
    addVec(8'h90, 1, 0, 0, 0, 0, 0);
    addVec(8'h3C, 1, 0, 0, 0, 0, 0);
    addVec(8'h64, 1, 1, 1, 7'd60, 7'd100, 4'd0);
    addVec(8'h40, 1, 0, 0, 0, 0, 0);
    addVec(8'h00, 1, 1, 0, 7'd64, 7'd0, 4'd0);
    // Real-time bytes interleaved inside a message.
    addVec(8'h90, 1, 0, 0, 0, 0, 0);
    addVec(8'hF8, 1, 0, 0, 0, 0, 0);
    addVec(8'h3C, 1, 0, 0, 0, 0, 0);
    addVec(8'hFE, 1, 0, 0, 0, 0, 0);
    addVec(8'h64, 1, 1, 1, 7'd60, 7'd100, 4'd0);
    // Bad stop bit while waiting for velocity drops key 0x30.
    addVec(8'h90, 1, 0, 0, 0, 0, 0);
    addVec(8'h30, 1, 0, 0, 0, 0, 0);
    addVec(8'h3C, 0, 0, 0, 0, 0, 0);
    addVec(8'h3C, 1, 0, 0, 0, 0, 0);
    addVec(8'h64, 1, 1, 1, 7'd60, 7'd100, 4'd0);
    // Channel filter: dut2 only accepts channel 2.
    addVec(8'h91, 1, 0, 0, 0, 0, 0);
    addVec(8'h3C, 1, 0, 0, 0, 0, 0);
    addVec(8'h64, 1, 1, 1, 7'd60, 7'd100, 4'd1);
    addVec(8'h92, 1, 0, 0, 0, 0, 0);
    addVec(8'h3C, 1, 0, 0, 0, 0, 0);
    addVec(8'h64, 1, 1, 1, 7'd60, 7'd100, 4'd2);
    // Explicit note-off status.
    addVec(8'h85, 1, 0, 0, 0, 0, 0);
    addVec(8'h3C, 1, 0, 0, 0, 0, 0);
    addVec(8'h40, 1, 1, 0, 7'd60, 7'd64, 4'd5);
    // Non-note status cancels running status mid-message.
    addVec(8'h90, 1, 0, 0, 0, 0, 0);
    addVec(8'h3C, 1, 0, 0, 0, 0, 0);
    addVec(8'hB0, 1, 0, 0, 0, 0, 0);
    addVec(8'h64, 1, 0, 0, 0, 0, 0);

    $display("[TB] reset state");
    waitClocks(5);
    checkOutput({m1_valid, m1_on, m1_key, m1_vel, m1_chan, f1_err} == 0, "dut1 reset outputs",
                {m1_valid, m1_on, m1_key, m1_vel, m1_chan, f1_err}, 0);
    checkOutput({m2_valid, m2_on, m2_key, m2_vel, m2_chan, f2_err} == 0, "dut2 reset outputs",
                {m2_valid, m2_on, m2_key, m2_vel, m2_chan, f2_err}, 0);
    rst_n = 1'b1;
    waitClocks(COUNT);

    $display("[TB] byte table");
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    $display("[TB] start glitch");
    serial = 1'b0;
    waitClocks(100);
    serial = 1'b1;
    waitClocks(2 * COUNT);
    checkCounts("glitch");

    $display("[TB] reset mid-byte");
    sendByte(8'h90, 1);
    sendByte(8'h3C, 1);
    serial = 1'b0;
    waitClocks(COUNT);
    serial = 1'b0; waitClocks(COUNT);
    serial = 1'b0; waitClocks(COUNT);
    serial = 1'b1; waitClocks(COUNT / 2);
    rst_n = 1'b0;
    #1;
    checkOutput({m1_valid, m1_on, m1_key, m1_vel, m1_chan, f1_err} == 0, "dut1 async reset outputs",
                {m1_valid, m1_on, m1_key, m1_vel, m1_chan, f1_err}, 0);
    checkOutput({m2_valid, m2_on, m2_key, m2_vel, m2_chan, f2_err} == 0, "dut2 async reset outputs",
                {m2_valid, m2_on, m2_key, m2_vel, m2_chan, f2_err}, 0);
    waitClocks(10);
    rst_n = 1'b1;
    have1 = 0; have2 = 0;
    waitClocks(COUNT);
    // Running status was cleared: bare data bytes produce nothing.
    applyStimulus('{8'h3C, 1, 0, 0, 0, 0, 0}, 100);
    applyStimulus('{8'h64, 1, 0, 0, 0, 0, 0}, 101);
    applyStimulus('{8'h90, 1, 0, 0, 0, 0, 0}, 102);
    applyStimulus('{8'h3C, 1, 0, 0, 0, 0, 0}, 103);
    applyStimulus('{8'h64, 1, 1, 1, 7'd60, 7'd100, 4'd0}, 104);

    checkOutput(q1.size() == 0, "dut1 queue drained", q1.size(), 0);
    checkOutput(q2.size() == 0, "dut2 queue drained", q2.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
